// File: rtl/mm_pkg.sv
// mm_pkg: shared widths and FSM state codes for the matrix-multiply sequencer.
// Imported by the sequencer top and its index counter.
package mm_pkg;

  localparam int DATA_WIDTH     = 8;
  localparam int N              = 4;
  localparam int IDX_WIDTH      = 4;
  localparam int OUT_DATA_WIDTH = 20;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_A  = 3'd1;
  localparam logic [2:0] S_LOAD_B  = 3'd2;
  localparam logic [2:0] S_COMPUTE = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_OUTPUT  = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

endpackage

// File: rtl/mm_sequencer_if.sv
// mm_sequencer_if: operand stream, engine bus and result stream bundle.
// MM_SEQ_RES_LAST_EN adds res_last to the result stream.
interface mm_sequencer_if #(
  parameter int DATA_WIDTH     = mm_pkg::DATA_WIDTH,
  parameter int IDX_WIDTH      = mm_pkg::IDX_WIDTH,
  parameter int OUT_DATA_WIDTH = mm_pkg::OUT_DATA_WIDTH
);

  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_WIDTH-1:0]     in_data;

  logic                      mm_wr_enable;
  logic                      mm_compute_enable;
  logic [DATA_WIDTH-1:0]     mm_in_data;
  logic [IDX_WIDTH-1:0]      mm_i;
  logic [IDX_WIDTH-1:0]      mm_j;
  logic                      mm_is_first_mat;
  logic [IDX_WIDTH-1:0]      mm_match_dim;
  logic [OUT_DATA_WIDTH-1:0] mm_out_data;

  logic                      res_valid;
  logic                      res_ready;
  logic [OUT_DATA_WIDTH-1:0] res_data;
  logic [IDX_WIDTH-1:0]      res_i;
  logic [IDX_WIDTH-1:0]      res_j;
`ifdef MM_SEQ_RES_LAST_EN
  logic                      res_last;
`endif

  modport master (
    input  in_valid, in_data, mm_out_data, res_ready,
    output in_ready, mm_wr_enable, mm_compute_enable,
    output mm_in_data, mm_i, mm_j, mm_is_first_mat,
    output mm_match_dim, res_valid, res_data, res_i, res_j
`ifdef MM_SEQ_RES_LAST_EN
    , output res_last
`endif
  );

  modport slave (
    output in_valid, in_data, mm_out_data, res_ready,
    input  in_ready, mm_wr_enable, mm_compute_enable,
    input  mm_in_data, mm_i, mm_j, mm_is_first_mat,
    input  mm_match_dim, res_valid, res_data, res_i, res_j
`ifdef MM_SEQ_RES_LAST_EN
    , input res_last
`endif
  );

endinterface

// File: rtl/mm_idx_counter.sv
// mm_idx_counter: row-major (i,j) walker wrapping at dim-1.
// last_o flags (dim-1,dim-1); an increment there returns to (0,0).
module mm_idx_counter #(
  parameter int IDX_WIDTH = mm_pkg::IDX_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr_i,
  input  logic                 inc_i,
  input  logic [IDX_WIDTH-1:0] dim_i,
  output logic [IDX_WIDTH-1:0] row_o,
  output logic [IDX_WIDTH-1:0] col_o,
  output logic                 last_o
);

  logic [IDX_WIDTH-1:0] i_q, i_d;
  logic [IDX_WIDTH-1:0] j_q, j_d;
  logic [IDX_WIDTH-1:0] lim;

  assign lim    = dim_i - IDX_WIDTH'(1);
  assign last_o = (i_q == lim) && (j_q == lim);
  assign row_o  = i_q;
  assign col_o  = j_q;

  // next index: column first, carry into row, full wrap after last
  always_comb begin
    i_d = i_q;
    j_d = j_q;
    if (clr_i) begin
      i_d = '0;
      j_d = '0;
    end else if (inc_i) begin
      if (j_q == lim) begin
        j_d = '0;
        i_d = last_o ? '0 : i_q + IDX_WIDTH'(1);
      end else begin
        j_d = j_q + IDX_WIDTH'(1);
      end
    end
  end

  // index registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_q <= '0;
      j_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
    end
  end

endmodule

// File: rtl/mm_sequencer.sv
// mm_sequencer: streams A/B into the engine, then issues one compute per
// result and streams results out. MM_SEQ_RES_LAST_EN adds res_last.
module mm_sequencer #(
  parameter int DATA_WIDTH     = mm_pkg::DATA_WIDTH,
  parameter int N              = mm_pkg::N,
  parameter int IDX_WIDTH      = mm_pkg::IDX_WIDTH,
  parameter int OUT_DATA_WIDTH = mm_pkg::OUT_DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [IDX_WIDTH-1:0] dim,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  mm_sequencer_if.master       bus
);

  import mm_pkg::*;

  logic [2:0]                state_q, state_d;
  logic [IDX_WIDTH-1:0]      dim_q, dim_d;
  logic                      err_q, err_d;
  logic [OUT_DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic [IDX_WIDTH-1:0]      res_i_q, res_i_d;
  logic [IDX_WIDTH-1:0]      res_j_q, res_j_d;
  logic [DATA_WIDTH-1:0]     wr_data;

  logic                 loading;
  logic                 wr_en;
  logic                 res_hs;
  logic                 dim_ok;
  logic [IDX_WIDTH-1:0] row, col;
  logic                 last;

  assign loading = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
  assign wr_en   = bus.in_valid && loading;
  assign res_hs  = (state_q == S_OUTPUT) && bus.res_ready;
  assign dim_ok  = (dim != '0) && (dim <= IDX_WIDTH'(N));
  assign wr_data = bus.in_data;

  mm_idx_counter #(.IDX_WIDTH(IDX_WIDTH)) u_idx (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (state_q == S_IDLE),
    .inc_i  (wr_en || res_hs),
    .dim_i  (dim_q),
    .row_o  (row),
    .col_o  (col),
    .last_o (last)
  );

  // job FSM: load A, load B, then compute/wait/output per element
  always_comb begin
    state_d    = state_q;
    dim_d      = dim_q;
    err_d      = 1'b0;
    res_data_d = res_data_q;
    res_i_d    = res_i_q;
    res_j_d    = res_j_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && dim_ok) begin
          dim_d   = dim;
          state_d = S_LOAD_A;
        end else if (start) begin
          err_d = 1'b1;
        end
      end
      S_LOAD_A:  if (wr_en && last) state_d = S_LOAD_B;
      S_LOAD_B:  if (wr_en && last) state_d = S_COMPUTE;
      S_COMPUTE: state_d = S_WAIT;
      S_WAIT: begin
        res_data_d = bus.mm_out_data;
        res_i_d    = row;
        res_j_d    = col;
        state_d    = S_OUTPUT;
      end
      S_OUTPUT:  if (res_hs) state_d = last ? S_DONE : S_COMPUTE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM, dim latch and result holding registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      dim_q      <= '0;
      err_q      <= 1'b0;
      res_data_q <= '0;
      res_i_q    <= '0;
      res_j_q    <= '0;
    end else begin
      state_q    <= state_d;
      dim_q      <= dim_d;
      err_q      <= err_d;
      res_data_q <= res_data_d;
      res_i_q    <= res_i_d;
      res_j_q    <= res_j_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign err  = err_q;

  assign bus.in_ready          = loading;
  assign bus.mm_wr_enable      = wr_en;
  assign bus.mm_compute_enable = (state_q == S_COMPUTE);
  assign bus.mm_in_data        = wr_data;
  assign bus.mm_i              = row;
  assign bus.mm_j              = col;
  assign bus.mm_is_first_mat   = (state_q != S_LOAD_B);
  assign bus.mm_match_dim      = dim_q;

  assign bus.res_valid = (state_q == S_OUTPUT);
  assign bus.res_data  = res_data_q;
  assign bus.res_i     = res_i_q;
  assign bus.res_j     = res_j_q;
`ifdef MM_SEQ_RES_LAST_EN
  assign bus.res_last  = (state_q == S_OUTPUT) && last;
`endif

endmodule
